// File: rtl/bin_to_dec_seq_pkg.sv
// Shared math definitions for the binary-to-decimal converter: default operand
// width, the BCD digit type and the converter FSM state encoding.
`ifndef INT_BITS
`define INT_BITS 32
`endif

package bin_to_dec_seq_pkg;

    localparam int BCD_W = 4;

    typedef logic [BCD_W-1:0] bcd_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CONV = 2'd1,
        DONE = 2'd2
    } conv_state_t;

endpackage

// File: rtl/divmod10_w.sv
// Combinational exact divide-by-10 of a WIDTH-bit unsigned value: a shift-add
// reciprocal estimate of x*0.8, scaled by 1/8, then one remainder correction.
module divmod10_w
    import bin_to_dec_seq_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] i_x,
    output logic [WIDTH-1:0] o_q,
    output bcd_t             o_r
);

    logic [WIDTH-1:0] w_q;
    logic [4:0]       w_rem;

    always_comb begin
        w_q = (i_x >> 1) + (i_x >> 2);
        for (int s = 4; s < WIDTH; s = s * 2) begin
            w_q = w_q + (w_q >> s);
        end
        w_q = w_q >> 3;
        // The estimate is never high and at most one low, so the true remainder
        // is below 20 and five bits of modular arithmetic are enough.
        w_rem = 5'(i_x) - 5'({w_q, 3'b000}) - 5'({w_q, 1'b0});
        if (w_rem > 5'd9) begin
            w_q   = w_q + WIDTH'(1);
            w_rem = w_rem - 5'd10;
        end
        o_q = w_q;
        o_r = w_rem[3:0];
    end

endmodule

// File: rtl/bin_to_dec_seq.sv
// Sequential binary-to-BCD converter: one decimal digit per cycle, least
// significant first, with valid/ready handshakes on both sides.
module bin_to_dec_seq
    import bin_to_dec_seq_pkg::*;
#(
    parameter int WIDTH  = `INT_BITS,
    parameter int DIGITS = 10,
    parameter int SIGNED = 0
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           in_valid,
    output logic                           in_ready,
    input  logic [WIDTH-1:0]               in_value,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic [4*DIGITS-1:0]            out_digits,
    output logic [$clog2(DIGITS+1)-1:0]    out_ndigits,
    output logic                           out_neg,
    output logic                           out_overflow,
    output conv_state_t                    dbg_state
);

    // Handshakes: a transfer happens on a rising edge where valid and ready are
    // both high; the producer holds its payload stable until that edge.

    localparam int CNT_W = $clog2(DIGITS+1);

    conv_state_t         r_state;
    conv_state_t         w_next_state;
    logic [WIDTH-1:0]    r_mag;
    logic [CNT_W-1:0]    r_cnt;
    logic [4*DIGITS-1:0] r_digits;
    logic [CNT_W-1:0]    r_ndigits;
    logic                r_neg;
    logic                r_ovf;

    logic [WIDTH-1:0]    w_quot;
    bcd_t                w_rem;
    logic                w_last;
    logic                w_in_neg;
    logic [WIDTH-1:0]    w_in_mag;

    divmod10_w #(.WIDTH(WIDTH)) u_divmod (
        .i_x (r_mag),
        .o_q (w_quot),
        .o_r (w_rem)
    );

    // Negating the most negative value wraps to 2^(WIDTH-1), which is exactly
    // the magnitude wanted when read back as unsigned.
    assign w_in_neg = (SIGNED != 0) && in_value[WIDTH-1];
    assign w_in_mag = w_in_neg ? (WIDTH'(0) - in_value) : in_value;
    assign w_last   = (w_quot == '0) || (r_cnt == CNT_W'(DIGITS-1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        unique case (r_state)
            IDLE:    if (in_valid)  w_next_state = CONV;
            CONV:    if (w_last)    w_next_state = DONE;
            DONE:    if (out_ready) w_next_state = IDLE;
            default:                w_next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_mag     <= '0;
            r_cnt     <= '0;
            r_digits  <= '0;
            r_ndigits <= '0;
            r_neg     <= 1'b0;
            r_ovf     <= 1'b0;
        end else if (r_state == IDLE && in_valid) begin
            r_mag     <= w_in_mag;
            r_neg     <= w_in_neg;
            r_cnt     <= '0;
            r_digits  <= '0;
            r_ndigits <= '0;
            r_ovf     <= 1'b0;
        end else if (r_state == CONV) begin
            r_mag <= w_quot;
            r_cnt <= r_cnt + CNT_W'(1);
            for (int i = 0; i < DIGITS; i++) begin
                if (CNT_W'(i) == r_cnt) begin
                    r_digits[i*BCD_W +: BCD_W] <= w_rem;
                end
            end
            if (w_last) begin
                r_ndigits <= r_cnt + CNT_W'(1);
                r_ovf     <= (w_quot != '0);
            end
        end
    end

    assign in_ready     = (r_state == IDLE);
    assign out_valid    = (r_state == DONE);
    assign out_digits   = r_digits;
    assign out_ndigits  = r_ndigits;
    assign out_neg      = r_neg;
    assign out_overflow = r_ovf;
    assign dbg_state    = r_state;

endmodule

// File: doc/bin_to_dec_seq.md
BIN_TO_DEC_SEQ -- requirements
Module: bin_to_dec_seq

Interface
REQ-001 SHALL have parameter WIDTH, default `INT_BITS, meaning input operand width in bits (>= 4).
REQ-002 SHALL have parameter DIGITS, default 10, meaning maximum decimal digits produced (>= 1).
REQ-003 SHALL have parameter SIGNED, default 0, meaning 1 = operand is two's complement, 0 = unsigned.
REQ-004 SHALL have port clk, input, 1, the single clock, rising-edge.
REQ-005 SHALL have port rst, input, 1, reset, asynchronous and active-high.
REQ-006 SHALL have port in_valid, input, 1, operand present.
REQ-007 SHALL have port in_ready, output, 1, block can accept an operand.
REQ-008 SHALL have port in_value, input, WIDTH, binary operand.
REQ-009 SHALL have port out_valid, output, 1, result present.
REQ-010 SHALL have port out_ready, input, 1, consumer takes the result.
REQ-011 SHALL have port out_digits, output, 4*DIGITS, BCD digits, digit 0 (least significant) at bits [3:0].
REQ-012 SHALL have port out_ndigits, output, $clog2(DIGITS+1), count of significant digits, 1..DIGITS.
REQ-013 SHALL have port out_neg, output, 1, operand was negative (always 0 when SIGNED=0).
REQ-014 SHALL have port out_overflow, output, 1, magnitude needs more than DIGITS digits.

Function
REQ-015 SHALL implement FSM states IDLE, CONV, DONE; in_ready = (state==IDLE); out_valid = (state==DONE).
REQ-016 SHALL, on in_valid && in_ready, capture magnitude (|in_value| if SIGNED and MSB set, else in_value) as WIDTH-bit unsigned, set out_neg accordingly, clear all digits, zero the digit counter, and go to CONV.
REQ-017 SHALL treat the most negative value as magnitude 2^(WIDTH-1) without loss.
REQ-018 SHALL, each CONV cycle, divide the working magnitude by 10 exactly, write the remainder to digit[counter], replace the magnitude with the quotient, and increment the counter.
REQ-019 SHALL leave CONV for DONE when the new quotient is 0 or the counter reaches DIGITS, whichever comes first.
REQ-020 SHALL, on leaving CONV, set out_ndigits = digits written and out_overflow = (quotient != 0).
REQ-021 SHALL give latency k cycles from the accept edge to out_valid high, where k = out_ndigits; an operand of 0 yields one digit, value 0, k = 1.
REQ-022 SHALL leave unwritten digit positions 0 (no blanking code).
REQ-023 SHALL hold all out_* signals stable in DONE until out_ready; on out_valid && out_ready it SHALL return to IDLE the next cycle.
REQ-024 SHALL ignore in_valid outside IDLE; there is no skid path, so the next accept occurs no earlier than the cycle after handshake.
REQ-025 SHALL, on overflow, keep the DIGITS least significant digits and report out_ndigits = DIGITS.

Reset
REQ-026 SHALL, on rst, go to IDLE asynchronously with out_valid=0, in_ready=1 after reset release, and out_digits, out_ndigits, out_neg, out_overflow, magnitude and counter all 0.
REQ-027 SHALL abandon any conversion in progress on rst with no partial output.

Structure
REQ-028 SHALL place the BCD digit typedef (4-bit) and FSM state enum in the shared math package; `INT_BITS SHALL remain in the math constants header.
REQ-029 SHALL use one combinational sub-module, divmod10_w (parameter WIDTH), giving exact quotient and remainder (0..9) of a WIDTH-bit unsigned value by 10 via shift-add reciprocal with a single correction step, verified exhaustively for WIDTH<=16 and randomly for WIDTH=32/64.
REQ-030 SHALL use at most one divmod10_w instance.

Verification
REQ-031 SHALL cover: WIDTH=32, DIGITS=10, in_value=12345 -> out_valid 5 cycles after accept, digits [5,4,3,2,1,0..], ndigits=5, overflow=0.
REQ-032 SHALL cover: in_value=0 -> out_valid 1 cycle after accept, ndigits=1, all digits 0.
REQ-033 SHALL cover: SIGNED=1, in_value=32'h8000_0000 -> out_neg=1, digits of 2147483648, ndigits=10, 10-cycle latency.
REQ-034 SHALL cover: DIGITS=4, in_value=12345 -> ndigits=4, digits 2345, overflow=1.
REQ-035 SHALL cover: out_ready low 5 cycles in DONE with in_valid held high -> outputs stable, in_ready=0, next operand accepted only after handshake.
REQ-036 SHALL cover: rst pulsed in cycle 3 of converting 4294967295 -> immediate IDLE, all outputs 0, following conversion of 7 correct.
